// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, and a one-entry
// IF/ID buffer handed to decode over valid/ready. Redirects squash in-flight fetches.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             decode_ready,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pcplus4
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_pc, r_req_addr, r_instr, r_instr_pc, r_pcplus4;
    logic             r_instr_valid;
    logic             w_buf_free, w_xfer, w_load;
    logic [WIDTH-1:0] w_redir_pc;

    assign w_buf_free = !r_instr_valid || decode_ready;
    assign imem_req   = (r_state == S_REQ) && w_buf_free && !redirect && !reset;
    assign w_xfer     = imem_req && imem_ready;
    assign w_load     = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_redir_pc = redirect_pc & ~{{(WIDTH-2){1'b0}}, 2'b11};

    // A response in S_WAIT always ends the transaction; a redirect alone turns it into a drop.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   if (w_xfer) w_next = S_WAIT;
            S_WAIT:  if (imem_rvalid) w_next = S_REQ;
                     else if (redirect) w_next = S_DROP;
            S_DROP:  if (imem_rvalid) w_next = S_REQ;
            default: w_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_req_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_pcplus4     <= '0;
        end else begin
            r_state <= w_next;
            if (redirect)    r_pc <= w_redir_pc;
            else if (w_xfer) r_pc <= r_pc + WIDTH'(4);
            if (w_xfer) r_req_addr <= r_pc;
            // Load beats consume, so a word arriving in a handshake cycle replaces the old one.
            if (redirect) begin
                r_instr_valid <= 1'b0;
            end else if (w_load) begin
                r_instr_valid <= 1'b1;
                r_instr       <= imem_rdata;
                r_instr_pc    <= r_req_addr;
                r_pcplus4     <= r_req_addr + WIDTH'(4);
            end else if (decode_ready) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign op          = r_instr[WIDTH-1 -: 6];
    assign instr_pc    = r_instr_pc;
    assign pcplus4     = r_pcplus4;

endmodule
